mem_loader: RTL and testbench
=============================

Name: mem_loader

Overview:
- Upstream sequencer for the DFF word memory. Turns an 8-bit byte stream into 16-bit word writes at auto-incrementing addresses (LOAD).
- Reads the whole memory back as a byte stream (DUMP).
- Drives the memory's addr/din/we/cs pins and consumes its dout. Replaces the address/write-enable forcing done during reset with a handshaked, clocked sequence.

Parameters:
ADDR_W, 3, memory address width; DEPTH = 2**ADDR_W words
DATA_W, 16, memory word width; fixed at 2 bytes, other values unsupported

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  synchronous, active-high reset
start_load  input  1  one-cycle pulse: begin LOAD sequence
start_dump  input  1  one-cycle pulse: begin DUMP sequence
byte_in  input  8  inbound data byte
byte_valid  input  1  byte_in valid
byte_ready  output  1  loader accepts byte_in this cycle
out_byte  output  8  outbound data byte
out_valid  output  1  out_byte valid
out_ready  input  1  downstream accepts out_byte
mem_addr  output  ADDR_W  memory address
mem_din  output  DATA_W  memory write data
mem_we  output  1  memory write enable
mem_cs  output  1  memory chip select
mem_dout  input  DATA_W  memory read data, valid 1 cycle after address presented with cs=1, we=0
busy  output  1  sequence in progress
done  output  1  one-cycle pulse when a sequence completes

Behaviour:
- Reset (rst=1 at clk edge):
  - State IDLE; addr counter=0; byte/word hold registers=0.
  - All outputs 0: byte_ready, out_valid, out_byte, mem_addr, mem_din, mem_we, mem_cs, busy, done.
- Reset mid-sequence aborts immediately. A partially assembled word is discarded, and mem_we is never asserted in the cycle after rst.
- Handshakes:
  - Input transfer when byte_valid & byte_ready.
  - Output transfer when out_valid & out_ready.
  - out_byte is stable while out_valid=1 and out_ready=0. out_valid never drops without a transfer except on rst.
- States:
  - IDLE: busy=0.
    - start_load -> LD_LO, addr=0.
    - Else start_dump -> RD_REQ, addr=0.
    - Both asserted together: load wins.
    - Starts are ignored whenever busy=1.
  - LD_LO: byte_ready=1. On transfer, low byte[7:0] is latched -> LD_HI.
  - LD_HI: byte_ready=1. On transfer, high byte[15:8] is latched -> LD_WR.
  - LD_WR: exactly one cycle with mem_we=1, mem_cs=1, mem_addr=addr, mem_din={hi,lo}. byte_ready=0.
    - addr==DEPTH-1 -> FIN.
    - Else addr+1 -> LD_LO.
  - RD_REQ: mem_cs=1, mem_we=0, mem_addr=addr for one cycle -> RD_CAP.
  - RD_CAP: mem_dout is captured into the word register -> TX_LO.
  - TX_LO: out_valid=1, out_byte=word[7:0]. On transfer -> TX_HI.
  - TX_HI: out_valid=1, out_byte=word[15:8]. On transfer:
    - addr==DEPTH-1 -> FIN.
    - Else addr+1 -> RD_REQ.
  - FIN: done=1 for one cycle, busy=1 -> IDLE.
- busy=1 in every state except IDLE.
- Address counter:
  - Width ADDR_W, increments only on completed words.
  - Never wraps inside a sequence; it terminates at DEPTH-1.
  - It is reset to 0 at each start.
- Byte order: little-endian; the first byte is bits [7:0].
- Throughput:
  - LOAD takes a minimum of 3 cycles/word (2 byte cycles + 1 write cycle).
  - DUMP takes a minimum of 4 cycles/word (request, capture, 2 byte cycles).
- mem_cs=0 and mem_we=0 in every state not listed above, so the memory is idle.
- mem_din and mem_addr hold their last value when mem_cs=0. Verification must not check them then.
- byte_valid outside LD_LO/LD_HI has no effect; those bytes are not consumed.
- out_ready outside TX states is ignored.

Test Plan:
- Reset: drive rst=1 for 2 cycles with random inputs -> all outputs 0, state IDLE; one cycle after release, busy=0.
- Full load: start_load, stream bytes 0x00..0x0F with byte_valid held high -> 8 writes. The write at addr k has mem_din={2k+1,2k}, e.g. addr 0 = 0x0100 and addr 7 = 0x0F0E. Exactly one mem_we cycle per word, done pulses once, 24 cycles from the first accept to FIN.
- Dump with backpressure: after full load, start_dump, toggle out_ready 1/0 each cycle -> out_byte sequence 0x00..0x0F in order, out_byte stable while stalled, then done pulse.
- Gapped input: during LOAD, insert 3-cycle byte_valid gaps between the low and high bytes -> no mem_we until the high byte is accepted; stored word is unchanged versus the gapless run.
- Simultaneous/ignored starts: start_load and start_dump in the same cycle -> LOAD runs. start_dump pulsed mid-load -> ignored, busy stays 1, no reads are issued.
- Abort: assert rst after the low byte of word 3 is accepted -> mem_we stays 0, state IDLE. A following full load then rewrites addr 0..7 correctly.

Source files
------------

// File: rtl/mem_loader.sv
// mem_loader: sequencer in front of a small synchronous word memory.
//
// LOAD turns an 8-bit byte stream into DATA_W-bit word writes at addresses
// 0..DEPTH-1. Bytes are little-endian, so the first byte of a pair is [7:0].
// DUMP reads every word back and emits it as a byte stream, low byte first.
//
// Ports
//   clk, rst               clock; synchronous active-high reset
//   start_load/start_dump  one-cycle start pulses, ignored while busy
//   byte_in/valid/ready    inbound byte stream (valid/ready handshake)
//   out_byte/valid/ready   outbound byte stream (valid/ready handshake)
//   mem_addr/din/we/cs     memory command pins
//   mem_dout               memory read data, one cycle after a read request
//   busy                   a sequence is in progress
//   done                   one-cycle pulse when a sequence completes
module mem_loader #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16   // two bytes per word; other widths unsupported
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_load,
    input  logic              start_dump,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [7:0]        out_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    output logic              mem_cs,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy,
    output logic              done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LD_LO,
        S_LD_HI,
        S_LD_WR,
        S_RD_REQ,
        S_RD_CAP,
        S_TX_LO,
        S_TX_HI,
        S_FIN
    } state_t;

    // Last word address (DEPTH-1); sequences stop here instead of wrapping.
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    // One word register serves both directions: it assembles the word being
    // loaded and holds the word captured from the memory during a dump.
    logic [DATA_W-1:0] data_q,  data_d;

    // NOTE: state registers use non-blocking assignments so every flop sees
    // the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Address and write data come straight from the registers, so they hold
    // their last value whenever the memory is not selected.
    assign mem_addr = addr_q;
    assign mem_din  = data_q;
    assign busy     = (state_q != S_IDLE);

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // skipped an assignment would otherwise infer a latch.
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        byte_ready = 1'b0;
        out_valid  = 1'b0;
        out_byte   = 8'h00;
        mem_we     = 1'b0;
        mem_cs     = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Load has priority when both starts arrive together.
                if (start_load) begin
                    state_d = S_LD_LO;
                    addr_d  = '0;
                end else if (start_dump) begin
                    state_d = S_RD_REQ;
                    addr_d  = '0;
                end
            end
            S_LD_LO: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    data_d[7:0] = byte_in;
                    state_d     = S_LD_HI;
                end
            end
            S_LD_HI: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    data_d[15:8] = byte_in;
                    state_d      = S_LD_WR;
                end
            end
            S_LD_WR: begin
                mem_cs = 1'b1;
                mem_we = 1'b1;
                if (addr_q == LAST_ADDR) begin
                    state_d = S_FIN;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_LD_LO;
                end
            end
            S_RD_REQ: begin
                mem_cs  = 1'b1;
                state_d = S_RD_CAP;
            end
            S_RD_CAP: begin
                // Read data is valid in the cycle after the request.
                data_d  = mem_dout;
                state_d = S_TX_LO;
            end
            S_TX_LO: begin
                out_valid = 1'b1;
                out_byte  = data_q[7:0];
                if (out_ready) begin
                    state_d = S_TX_HI;
                end
            end
            S_TX_HI: begin
                out_valid = 1'b1;
                out_byte  = data_q[15:8];
                if (out_ready) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_FIN;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_loader.sv
// Directed testbench for mem_loader with a behavioural word memory attached.
module tb_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_load, start_dump;
    logic [7:0]  byte_in;
    logic        byte_valid, byte_ready;
    logic [7:0]  out_byte;
    logic        out_valid, out_ready;
    logic [2:0]  mem_addr;
    logic [15:0] mem_din;
    logic        mem_we, mem_cs;
    logic [15:0] mem_dout;
    logic        busy, done;

    mem_loader #(.ADDR_W(3), .DATA_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_load (start_load),
        .start_dump (start_dump),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .out_byte   (out_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_we     (mem_we),
        .mem_cs     (mem_cs),
        .mem_dout   (mem_dout),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Memory model and event counters, all owned by the monitor process.
    logic [15:0] tb_mem [8];
    logic        clr_mem, clr_cnt;
    int          cyc_cnt = 0;
    int          we_cnt, rd_cnt, done_cnt, acc_cyc, done_cyc;

    always @(posedge clk) begin
        cyc_cnt = cyc_cnt + 1;
        if (clr_mem) begin
            for (int k = 0; k < 8; k++) tb_mem[k] <= 16'h0000;
            mem_dout <= 16'h0000;
        end
        if (clr_cnt) begin
            we_cnt   = 0;
            rd_cnt   = 0;
            done_cnt = 0;
            acc_cyc  = -1;
            done_cyc = -1;
        end else begin
            if (mem_cs && mem_we) begin
                tb_mem[mem_addr] <= mem_din;
                we_cnt = we_cnt + 1;
            end
            if (mem_cs && !mem_we) begin
                mem_dout <= tb_mem[mem_addr];
                rd_cnt = rd_cnt + 1;
            end
            if (byte_valid && byte_ready && acc_cyc < 0) acc_cyc = cyc_cnt;
            if (done) begin
                done_cnt = done_cnt + 1;
                if (done_cyc < 0) done_cyc = cyc_cnt;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear(input bit mem_too);
        clr_cnt = 1'b1;
        clr_mem = mem_too;
        tick();
        clr_cnt = 1'b0;
        clr_mem = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (busy && guard < 300) begin
            tick();
            guard++;
        end
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    // Presents one byte and returns once it has been accepted.
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("byte_ready_wait", 32'(byte_ready), 32'd1);
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic load_words(input logic [7:0] base, input bit gaps,
                              input bit both_starts, input bit mid_dump);
        start_load = 1'b1;
        start_dump = both_starts;
        tick();
        start_load = 1'b0;
        start_dump = 1'b0;
        check("load_entered", 32'(byte_ready), 32'd1);
        for (int i = 0; i < 16; i++) begin
            send_byte(base + 8'(i));
            if (gaps && (i % 2 == 0)) begin
                for (int g = 0; g < 3; g++) begin
                    check("gap_no_we", 32'(mem_we), 32'd0);
                    tick();
                end
            end
            if (mid_dump && i == 5) begin
                start_dump = 1'b1;
                tick();
                start_dump = 1'b0;
                check("mid_dump_busy", 32'(busy), 32'd1);
            end
        end
        wait_idle();
    endtask

    // Word k must hold {base+2k+1, base+2k}.
    task automatic check_mem(input logic [7:0] base);
        logic [7:0] lo, hi;
        for (int k = 0; k < 8; k++) begin
            lo = base + 8'(2 * k);
            hi = lo + 8'd1;
            check($sformatf("mem_word_%0d", k), 32'(tb_mem[k]), 32'({hi, lo}));
        end
    endtask

    initial begin
        int idx, guard;
        bit prev_stall;
        logic [7:0] prev_byte;

        // Reset with random inputs for two cycles.
        rst        = 1'b1;
        clr_cnt    = 1'b1;
        clr_mem    = 1'b1;
        start_load = 1'($urandom);
        start_dump = 1'($urandom);
        byte_in    = 8'($urandom);
        byte_valid = 1'($urandom);
        out_ready  = 1'($urandom);
        tick();
        start_load = 1'($urandom);
        start_dump = 1'($urandom);
        byte_valid = 1'($urandom);
        tick();
        clr_cnt = 1'b0;
        clr_mem = 1'b0;
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_done",       32'(done),       32'd0);
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_out_byte",   32'(out_byte),   32'd0);
        check("rst_mem_we",     32'(mem_we),     32'd0);
        check("rst_mem_cs",     32'(mem_cs),     32'd0);
        check("rst_mem_addr",   32'(mem_addr),   32'd0);
        check("rst_mem_din",    32'(mem_din),    32'd0);
        rst        = 1'b0;
        start_load = 1'b0;
        start_dump = 1'b0;
        byte_valid = 1'b0;
        out_ready  = 1'b0;
        tick();
        check("post_rst_busy", 32'(busy), 32'd0);

        // Gapless full load.
        clear(1'b1);
        load_words(8'h00, 1'b0, 1'b0, 1'b0);
        check_mem(8'h00);
        check("load_we_count",   32'(we_cnt),            32'd8);
        check("load_done_count", 32'(done_cnt),          32'd1);
        check("load_no_reads",   32'(rd_cnt),            32'd0);
        check("load_cycles",     32'(done_cyc - acc_cyc), 32'd24);

        // Dump with out_ready toggling every cycle.
        clear(1'b0);
        start_dump = 1'b1;
        tick();
        start_dump = 1'b0;
        check("dump_busy", 32'(busy), 32'd1);
        idx        = 0;
        guard      = 0;
        prev_stall = 1'b0;
        prev_byte  = 8'h00;
        while (idx < 16 && guard < 400) begin
            if (out_valid) begin
                if (prev_stall) check("dump_stable", 32'(out_byte), 32'(prev_byte));
                if (out_ready) begin
                    check($sformatf("dump_byte_%0d", idx), 32'(out_byte), 32'(idx));
                    idx++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_byte  = out_byte;
                end
            end
            tick();
            out_ready = ~out_ready;
            guard++;
        end
        out_ready = 1'b0;
        check("dump_byte_count", 32'(idx), 32'd16);
        wait_idle();
        check("dump_done_count", 32'(done_cnt), 32'd1);
        check("dump_reads",      32'(rd_cnt),   32'd8);
        check("dump_no_writes",  32'(we_cnt),   32'd0);

        // Gapped load into a cleared memory must store the same words.
        clear(1'b1);
        load_words(8'h00, 1'b1, 1'b0, 1'b0);
        check_mem(8'h00);
        check("gap_we_count", 32'(we_cnt), 32'd8);

        // Both starts together, then a start_dump pulse mid-load.
        clear(1'b1);
        load_words(8'h40, 1'b0, 1'b1, 1'b1);
        check_mem(8'h40);
        check("both_we_count",   32'(we_cnt),   32'd8);
        check("both_no_reads",   32'(rd_cnt),   32'd0);
        check("both_done_count", 32'(done_cnt), 32'd1);

        // Abort after the low byte of word 3.
        clear(1'b1);
        start_load = 1'b1;
        tick();
        start_load = 1'b0;
        for (int i = 0; i < 7; i++) send_byte(8'(i));
        byte_in    = 8'h07;
        byte_valid = 1'b1;
        rst        = 1'b1;
        tick();
        check("abort_we_in_rst",  32'(mem_we), 32'd0);
        check("abort_busy",       32'(busy),   32'd0);
        rst = 1'b0;
        tick();
        check("abort_we_after",   32'(mem_we),     32'd0);
        check("abort_idle",       32'(busy),       32'd0);
        check("abort_no_ready",   32'(byte_ready), 32'd0);
        byte_valid = 1'b0;
        tick();
        check("abort_we_count",   32'(we_cnt),     32'd3);
        check("abort_word2",      32'(tb_mem[2]),  32'h0504);
        check("abort_word3",      32'(tb_mem[3]),  32'h0000);

        // Full reload after the abort.
        clear(1'b1);
        load_words(8'h80, 1'b0, 1'b0, 1'b0);
        check_mem(8'h80);
        check("reload_we_count", 32'(we_cnt), 32'd8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
